// File: rtl/sha_digest_writer.sv
`timescale 1ns/1ps
// sha_digest_writer: buffers finished SHA-256 digests in a small FIFO and
// writes each one as a single 64-byte record into a host ring buffer over
// the AXI AW/W/B channels. A credit counter bounds outstanding writes and a
// soft-register window configures the ring and reports completion status.
//
// Optional build macro SHA_WB_IRQ_EN: adds the irq output and the 0x68
// irq_thresh register (interrupt every irq_thresh completed writes).
//
// Handshake rule used on every channel: a transfer happens on a rising clk
// edge where valid and ready are both high; valid never depends on ready,
// and the payload is held stable while valid is high and ready is low.
module sha_digest_writer #(
  parameter int LOG_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         digest_valid,
  output logic         digest_ready,
  input  logic [255:0] digest_data,
  input  logic [63:0]  digest_count,
  output logic [15:0]  awid_m,
  output logic [63:0]  awaddr_m,
  output logic [7:0]   awlen_m,
  output logic [2:0]   awsize_m,
  output logic         awvalid_m,
  input  logic         awready_m,
  output logic [15:0]  wid_m,
  output logic [511:0] wdata_m,
  output logic [63:0]  wstrb_m,
  output logic         wlast_m,
  output logic         wvalid_m,
  input  logic         wready_m,
  input  logic [15:0]  bid_m,
  input  logic [1:0]   bresp_m,
  input  logic         bvalid_m,
  output logic         bready_m,
  input  logic         softreg_req_valid,
  input  logic         softreg_req_isWrite,
  input  logic [31:0]  softreg_req_addr,
  input  logic [63:0]  softreg_req_data,
`ifdef SHA_WB_IRQ_EN
  output logic         irq,
`endif
  output logic         softreg_resp_valid,
  output logic [63:0]  softreg_resp_data
);

  localparam int         DEPTH      = 1 << LOG_DEPTH;
  localparam int         PW         = LOG_DEPTH + 1;
  localparam logic [4:0] CREDIT_MAX = 5'(MAX_OUTSTANDING);

  // Digest FIFO storage; pointers carry one extra bit to tell full from empty.
  logic [255:0]  mem_digest [DEPTH];
  logic [63:0]   mem_count  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fifo_level;
  // Number of FIFO entries (from the head) whose AW has already been issued.
  logic [PW-1:0] aw_sent;

  logic [63:0] base;
  logic [63:0] seq;
  logic [63:0] done_count;
  logic [31:0] ring_entries;
  logic [31:0] wr_idx;
  logic [31:0] err_count;
  logic [4:0]  credits;

  logic push;
  logic aw_hs;
  logic w_hs;
  logic aw_pending;
  logic sr_wr;
  logic sr_rd;
  logic wr_base;
  logic wr_ring;
  logic wr_credits;
  logic rd_in_window;
  logic [63:0] rd_value;

  // bid_m carries no information for a single-ID master.
  logic unused_bits;
  assign unused_bits = ^bid_m;

  assign fifo_level   = wr_ptr - rd_ptr;
  assign digest_ready = (fifo_level != PW'(DEPTH));
  assign push         = digest_valid && digest_ready;
  assign aw_pending   = (fifo_level != aw_sent);

  // AW is only offered with a credit in hand and a configured ring.
  assign awvalid_m = aw_pending && (credits != 5'd0) && (ring_entries != 32'd0);
  assign awaddr_m  = {base[63:6], 6'b0} + {26'd0, wr_idx, 6'd0};
  assign awlen_m   = 8'd0;
  assign awsize_m  = 3'b110;
  assign awid_m    = 16'd0;
  assign aw_hs     = awvalid_m && awready_m;

  // W follows its AW: the head entry is writable once its AW has gone out.
  assign wvalid_m = (aw_sent != '0);
  assign wdata_m  = {128'd0, seq, mem_count[rd_ptr[LOG_DEPTH-1:0]],
                     mem_digest[rd_ptr[LOG_DEPTH-1:0]]};
  assign wstrb_m  = {64{1'b1}};
  assign wlast_m  = 1'b1;
  assign wid_m    = 16'd0;
  assign w_hs     = wvalid_m && wready_m;

  assign bready_m = 1'b1;

  assign sr_wr        = softreg_req_valid && softreg_req_isWrite;
  assign sr_rd        = softreg_req_valid && !softreg_req_isWrite;
  assign wr_base      = sr_wr && (softreg_req_addr == 32'h40);
  assign wr_ring      = sr_wr && (softreg_req_addr == 32'h48);
  assign wr_credits   = sr_wr && (softreg_req_addr == 32'h50);
  assign rd_in_window = (softreg_req_addr >= 32'h40) && (softreg_req_addr <= 32'h68);

  // FIFO data write; storage needs no reset because pointers guard it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_digest[wr_ptr[LOG_DEPTH-1:0]] <= digest_data;
      mem_count[wr_ptr[LOG_DEPTH-1:0]]  <= digest_count;
    end
  end

  // Datapath state: FIFO pointers, AW bookkeeping, ring index, sequence,
  // credits and completion counters. Soft-register writes take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      aw_sent      <= '0;
      base         <= 64'd0;
      ring_entries <= 32'd0;
      wr_idx       <= 32'd0;
      seq          <= 64'd0;
      done_count   <= 64'd0;
      err_count    <= 32'd0;
      credits      <= CREDIT_MAX;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (w_hs) rd_ptr <= rd_ptr + 1'b1;

      if (aw_hs && !w_hs)      aw_sent <= aw_sent + 1'b1;
      else if (!aw_hs && w_hs) aw_sent <= aw_sent - 1'b1;

      if (wr_base) base <= softreg_req_data;

      if (wr_ring) begin
        ring_entries <= softreg_req_data[31:0];
        wr_idx       <= 32'd0;
        seq          <= 64'd0;
      end else begin
        if (aw_hs) wr_idx <= (wr_idx == ring_entries - 32'd1) ? 32'd0 : wr_idx + 32'd1;
        if (w_hs)  seq    <= seq + 64'd1;
      end

      if (wr_credits)                                    credits <= softreg_req_data[4:0];
      else if (aw_hs && !bvalid_m)                       credits <= credits - 5'd1;
      else if (!aw_hs && bvalid_m && credits < CREDIT_MAX) credits <= credits + 5'd1;

      if (bvalid_m) begin
        done_count <= done_count + 64'd1;
        if (bresp_m != 2'b00) err_count <= err_count + 32'd1;
      end
    end
  end

`ifdef SHA_WB_IRQ_EN
  logic [31:0] irq_thresh;
  logic [31:0] irq_cnt;
  logic        wr_irq;
  assign wr_irq = sr_wr && (softreg_req_addr == 32'h68);

  // Completion interrupt: one-cycle pulse each time irq_thresh B responses
  // have been counted since the last pulse or threshold write.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_thresh <= 32'd0;
      irq_cnt    <= 32'd0;
      irq        <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (wr_irq) begin
        irq_thresh <= softreg_req_data[31:0];
        irq_cnt    <= 32'd0;
      end else if (bvalid_m) begin
        if ((irq_thresh != 32'd0) && (irq_cnt + 32'd1 == irq_thresh)) begin
          irq     <= 1'b1;
          irq_cnt <= 32'd0;
        end else begin
          irq_cnt <= irq_cnt + 32'd1;
        end
      end
    end
  end
`endif

  // Read mux for the soft-register window.
  always_comb begin
    rd_value = 64'd0;
    case (softreg_req_addr)
      32'h40:  rd_value = base;
      32'h48:  rd_value = {32'd0, ring_entries};
      32'h50:  rd_value = {59'd0, credits};
      32'h58:  rd_value = done_count;
      32'h60:  rd_value = {err_count, wr_idx};
`ifdef SHA_WB_IRQ_EN
      32'h68:  rd_value = {32'd0, irq_thresh};
`else
      32'h68:  rd_value = 64'd0;
`endif
      default: rd_value = 64'd0;
    endcase
  end

  // Read response one cycle after the request; data stays zero when idle so
  // the parent can OR it with other responders.
  always_ff @(posedge clk) begin
    if (rst) begin
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= 64'd0;
    end else begin
      softreg_resp_valid <= sr_rd && rd_in_window;
      softreg_resp_data  <= (sr_rd && rd_in_window) ? rd_value : 64'd0;
    end
  end

endmodule
